// File: rtl/boot_rom_streamer.sv
`default_nettype none
// ============================================================================
// Module   : boot_rom_streamer
// Purpose  : Packs a boot-image byte stream little-endian into 32-bit words,
//            buffers them in a small FIFO and hands them to the CPC loader
//            over a 4-phase req/ack handshake. Flags completion once the
//            last word has been acknowledged.
// Options  : BOOT_CHECKSUM_EN - adds a 16-bit running byte checksum output.
// Revision : 1.0 - initial release
// ============================================================================
module boot_rom_streamer #(
    parameter int unsigned FIFO_DEPTH = 4,      // power of two, >= 2
    parameter logic [7:0]  PAD_BYTE   = 8'hFF
) (
    input  logic        ck16,
    input  logic        reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] host_bootdata,
    output logic        host_bootdata_req,
    input  logic        host_bootdata_ack,
    output logic [15:0] word_count,
    output logic        done,
    output logic        overrun
`ifdef BOOT_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FIFO_FULL = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_REQ     = 2'd1;
    localparam logic [1:0] c_RELEASE = 2'd2;

    // Packer state
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         hold_q, hold_d;
    logic                closed_q, closed_d;
    logic                overrun_q, overrun_d;

    // FIFO state
    logic [31:0]         fifo_mem_q [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]  count_q, count_d;

    // Output side state
    logic [1:0]          state_q, state_d;
    logic [31:0]         data_q, data_d;
    logic [15:0]         word_count_q, word_count_d;
    logic                done_q, done_d;

    // Combinational helpers
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_accept;
    logic                w_fifo_wr;
    logic                w_fifo_rd;
    logic                w_word_inc;
    logic                w_done_set;
    logic [31:0]         w_word;

    // Input handshake and FIFO status; in_ready depends on registered state only
    always_comb begin
        w_fifo_full  = (count_q == c_FIFO_FULL);
        w_fifo_empty = (count_q == '0);
        in_ready     = !closed_q && !w_fifo_full;
        w_accept     = in_valid && in_ready;
        w_fifo_wr    = w_accept && ((byte_idx_q == 2'd3) || in_last);
    end

    // Assemble the outgoing word: held lanes below, new byte, pad above
    always_comb begin
        case (byte_idx_q)
            2'd0:    w_word = {PAD_BYTE, PAD_BYTE, PAD_BYTE, in_data};
            2'd1:    w_word = {PAD_BYTE, PAD_BYTE, in_data, hold_q[7:0]};
            2'd2:    w_word = {PAD_BYTE, in_data, hold_q[15:0]};
            default: w_word = {in_data, hold_q[23:0]};
        endcase
    end

    // Packer next state: lane index, holding register, close and overrun flags
    always_comb begin
        byte_idx_d = byte_idx_q;
        hold_d     = hold_q;
        closed_d   = closed_q;
        overrun_d  = overrun_q;
        if (w_accept) begin
            if (w_fifo_wr) begin
                byte_idx_d = 2'd0;
            end else begin
                byte_idx_d = byte_idx_q + 2'd1;
                case (byte_idx_q)
                    2'd0:    hold_d[7:0]   = in_data;
                    2'd1:    hold_d[15:8]  = in_data;
                    default: hold_d[23:16] = in_data;
                endcase
            end
            if (in_last) begin
                closed_d = 1'b1;
            end
        end
        // Bytes offered after the image closed are dropped but remembered
        if (closed_q && in_valid) begin
            overrun_d = 1'b1;
        end
    end

    // Packer registers
    always_ff @(posedge ck16 or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx_q <= 2'd0;
            hold_q     <= 24'd0;
            closed_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            byte_idx_q <= byte_idx_d;
            hold_q     <= hold_d;
            closed_q   <= closed_d;
            overrun_q  <= overrun_d;
        end
    end

    // FIFO pointer/occupancy next state; write-plus-pop leaves count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_fifo_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_fifo_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_fifo_wr, w_fifo_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO control registers; flushing the pointers empties the buffer
    always_ff @(posedge ck16 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge ck16) begin
        if (w_fifo_wr) begin
            fifo_mem_q[wr_ptr_q] <= w_word;
        end
    end

    // Handshake FSM state register
    always_ff @(posedge ck16 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (!w_fifo_empty) begin
                    state_d = c_REQ;
                end
            end
            c_REQ: begin
                if (host_bootdata_ack) begin
                    state_d = c_RELEASE;
                end
            end
            c_RELEASE: begin
                if (!host_bootdata_ack) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Handshake FSM outputs; req is decoded from state so reset drops it at once
    always_comb begin
        host_bootdata_req = (state_q == c_REQ);
        w_fifo_rd         = (state_q == c_IDLE) && !w_fifo_empty;
        w_word_inc        = (state_q == c_REQ) && host_bootdata_ack;
        w_done_set        = (state_q == c_RELEASE) && !host_bootdata_ack &&
                            closed_q && w_fifo_empty && (byte_idx_q == 2'd0);
    end

    // Output datapath next state: launch word, delivered count, sticky done
    always_comb begin
        data_d       = data_q;
        word_count_d = word_count_q;
        done_d       = done_q;
        if (w_fifo_rd) begin
            data_d = fifo_mem_q[rd_ptr_q];
        end
        if (w_word_inc) begin
            word_count_d = word_count_q + 16'd1;
        end
        if (w_done_set) begin
            done_d = 1'b1;
        end
    end

    // Output datapath registers
    always_ff @(posedge ck16 or negedge reset_n) begin
        if (!reset_n) begin
            data_q       <= 32'd0;
            word_count_q <= 16'd0;
            done_q       <= 1'b0;
        end else begin
            data_q       <= data_d;
            word_count_q <= word_count_d;
            done_q       <= done_d;
        end
    end

    assign host_bootdata = data_q;
    assign word_count    = word_count_q;
    assign done          = done_q;
    assign overrun       = overrun_q;

`ifdef BOOT_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    // Running sum of accepted image bytes; pad lanes never enter the sum
    always_comb begin
        checksum_d = checksum_q;
        if (w_accept && !closed_q) begin
            checksum_d = checksum_q + {8'h00, in_data};
        end
    end

    // Checksum register
    always_ff @(posedge ck16 or negedge reset_n) begin
        if (!reset_n) begin
            checksum_q <= 16'd0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_boot_rom_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_rom_streamer
// Purpose  : Self-checking bench for boot_rom_streamer. Expected words are
//            packed from the image bytes with plain arithmetic; a consumer
//            model drives the req/ack handshake with random delays.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_rom_streamer;

    localparam int unsigned DEPTH   = 4;
    localparam logic [7:0]  PAD     = 8'hFF;
    localparam int          TIMEOUT = 3000;

    logic        ck16 = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [31:0] host_bootdata;
    logic        host_bootdata_req;
    logic        host_bootdata_ack = 1'b0;
    logic [15:0] word_count;
    logic        done;
    logic        overrun;
`ifdef BOOT_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  img   [$];
    logic [31:0] exp_q [$];

    always #5 ck16 = ~ck16;

    boot_rom_streamer #(
        .FIFO_DEPTH (DEPTH),
        .PAD_BYTE   (PAD)
    ) dut (
        .ck16              (ck16),
        .reset_n           (reset_n),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_last           (in_last),
        .in_ready          (in_ready),
        .host_bootdata     (host_bootdata),
        .host_bootdata_req (host_bootdata_req),
        .host_bootdata_ack (host_bootdata_ack),
        .word_count        (word_count),
        .done              (done),
        .overrun           (overrun)
`ifdef BOOT_CHECKSUM_EN
        ,
        .checksum          (checksum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck16);
        #1;
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, ":req"},        host_bootdata_req, 1'b0);
        chk({name, ":data"},       host_bootdata, 32'd0);
        chk({name, ":word_count"}, word_count, 16'd0);
        chk({name, ":done"},       done, 1'b0);
        chk({name, ":overrun"},    overrun, 1'b0);
        chk({name, ":in_ready"},   in_ready, 1'b1);
`ifdef BOOT_CHECKSUM_EN
        chk({name, ":checksum"},   checksum, 16'd0);
`endif
    endtask

    task automatic do_reset();
        in_valid          = 1'b0;
        in_last           = 1'b0;
        in_data           = 8'h00;
        host_bootdata_ack = 1'b0;
        reset_n           = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        reset_n = 1'b1;
        tick();
    endtask

    // Stream img[] (last byte flagged) and consume words with random delays.
    // hold_ack: no ack before this cycle; ovr_pulse: offer a byte 2 cycles after close.
    task automatic run_image(input string name, input int gap_pct, input int ack_dly_max,
                             input int rel_dly_max, input int hold_ack, input bit ovr_pulse);
        int          n, nwords, sent, exp_wc, cyc, dly, since_close, bp_exp;
        bit          exp_done, exp_ovr, closed, req_seen, got_word;
        bit          acc, wc_inc, done_set, ovr_set;
        logic [31:0] held, w;
        logic [15:0] sum;
        n      = img.size();
        nwords = (n + 3) / 4;
        exp_q.delete();
        for (int i = 0; i < n; i += 4) begin
            w = {4{PAD}};
            for (int j = 0; j < 4; j++) begin
                if (i + j < n) w[8*j +: 8] = img[i + j];
            end
            exp_q.push_back(w);
        end
        bp_exp = (n < 4 * (DEPTH + 1)) ? n : 4 * (DEPTH + 1);
        sent = 0; exp_wc = 0; cyc = 0; since_close = 0;
        dly = $urandom_range(0, ack_dly_max);
        exp_done = 0; exp_ovr = 0; closed = 0; req_seen = 0; got_word = 0;
        held = '0; sum = '0;
        while (!exp_done && cyc < TIMEOUT) begin
            chk({name, ":word_count"}, word_count, exp_wc);
            chk({name, ":done"}, done, exp_done);
            chk({name, ":overrun"}, overrun, exp_ovr);
            if (closed) chk({name, ":in_ready_closed"}, in_ready, 1'b0);
            if (host_bootdata_req) begin
                if (!req_seen) begin
                    w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                    chk({name, ":word"}, host_bootdata, w);
                    held = host_bootdata;
                    got_word = 1;
                end else begin
                    chk({name, ":data_stable"}, host_bootdata, held);
                end
            end else if (got_word) begin
                chk({name, ":data_hold"}, host_bootdata, held);
            end else begin
                chk({name, ":data_zero"}, host_bootdata, 32'd0);
            end
            req_seen = host_bootdata_req;
            if (hold_ack > 0 && cyc == hold_ack - 1) begin
                chk({name, ":bp_accepted"}, sent, bp_exp);
                if (n > bp_exp) chk({name, ":bp_in_ready"}, in_ready, 1'b0);
            end

            // producer
            acc = 0; ovr_set = 0;
            in_valid = 1'b0; in_last = 1'b0; in_data = 8'($urandom);
            if (sent < n) begin
                if ($urandom_range(0, 99) >= gap_pct) begin
                    in_valid = 1'b1;
                    in_data  = img[sent];
                    in_last  = (sent == n - 1);
                    acc      = in_ready;
                end
            end else if (ovr_pulse && closed && since_close == 1) begin
                in_valid = 1'b1;
                in_last  = 1'($urandom_range(0, 1));
                ovr_set  = 1;
            end

            // consumer
            wc_inc = 0; done_set = 0;
            if (!host_bootdata_ack) begin
                if (host_bootdata_req && cyc >= hold_ack) begin
                    if (dly == 0) begin
                        host_bootdata_ack = 1'b1;
                        wc_inc = 1;
                        dly = $urandom_range(0, rel_dly_max);
                    end else begin
                        dly--;
                    end
                end
            end else begin
                if (dly == 0) begin
                    host_bootdata_ack = 1'b0;
                    if (exp_wc == nwords) done_set = 1;
                    dly = $urandom_range(0, ack_dly_max);
                end else begin
                    dly--;
                end
            end

            if (closed) since_close++;
            tick();
            cyc++;
            if (acc) begin
                sum = sum + {8'h00, img[sent]};
                if (sent == n - 1) closed = 1;
                sent++;
            end
            exp_wc = exp_wc + int'(wc_inc);
            if (done_set) exp_done = 1;
            if (ovr_set)  exp_ovr  = 1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({name, ":in_time"}, (cyc < TIMEOUT), 1'b1);
        chk({name, ":final_done"}, done, 1'b1);
        chk({name, ":final_word_count"}, word_count, nwords);
        chk({name, ":final_overrun"}, overrun, exp_ovr);
        chk({name, ":words_left"}, exp_q.size(), 0);
`ifdef BOOT_CHECKSUM_EN
        chk({name, ":checksum"}, checksum, sum);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;

        // 1. Reset values
        do_reset();

        // 2. Full words 01..08
        img.delete();
        for (int i = 1; i <= 8; i++) img.push_back(8'(i));
        run_image("full", 0, 0, 0, 0, 0);
`ifdef BOOT_CHECKSUM_EN
        chk("full:checksum_const", checksum, 16'h0024);
`endif

        // 3. Partial final word
        do_reset();
        img.delete();
        img.push_back(8'hAA); img.push_back(8'hBB); img.push_back(8'hCC);
        run_image("partial", 0, 0, 0, 0, 0);

        // 4. Back-pressure: ack held off while 24 bytes are offered
        do_reset();
        img.delete();
        for (int i = 0; i < 24; i++) img.push_back(8'(i));
        run_image("bp", 0, 0, 0, 30, 0);

        // 5. Overrun after the last byte
        do_reset();
        img.delete();
        for (int i = 0; i < 10; i++) img.push_back(8'($urandom));
        run_image("ovr", 0, 0, 0, 0, 1);
        chk("ovr:sticky", overrun, 1'b1);

        // 6. Zero-length image never completes
        do_reset();
        repeat (10) tick();
        chk("empty:done", done, 1'b0);
        chk("empty:req", host_bootdata_req, 1'b0);

        // 7. Reset while a request is outstanding
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !host_bootdata_req; k++) tick();
        chk("rst:req_before", host_bootdata_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("rst_async");
        tick();
        reset_n = 1'b1;
        tick();
        check_reset_vals("rst_release");
        img.delete();
        for (int i = 0; i < 4; i++) img.push_back(8'($urandom));
        run_image("rst_new", 0, 1, 1, 0, 0);

        // 8. Ack held high after the first word
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 1); in_last = (i == 7);
            chk("stuck:in_ready", in_ready, 1'b1);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        for (int k = 0; k < 10 && !host_bootdata_req; k++) tick();
        chk("stuck:req1", host_bootdata_req, 1'b1);
        chk("stuck:word1", host_bootdata, 32'h04030201);
        host_bootdata_ack = 1'b1;
        tick();
        chk("stuck:wc1", word_count, 16'd1);
        repeat (10) begin
            tick();
            chk("stuck:no_req", host_bootdata_req, 1'b0);
        end
        host_bootdata_ack = 1'b0;
        tick();
        chk("stuck:idle_gap", host_bootdata_req, 1'b0);
        tick();
        chk("stuck:req2", host_bootdata_req, 1'b1);
        chk("stuck:word2", host_bootdata, 32'h08070605);
        host_bootdata_ack = 1'b1;
        tick();
        host_bootdata_ack = 1'b0;
        tick();
        chk("stuck:done", done, 1'b1);
        chk("stuck:wc2", word_count, 16'd2);

        // 9. Randomised images
        for (int r = 0; r < 8; r++) begin
            do_reset();
            img.delete();
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) img.push_back(8'($urandom));
            run_image($sformatf("rand%0d", r), $urandom_range(0, 60), $urandom_range(0, 3),
                      $urandom_range(0, 12), 0, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
